// File: rtl/dcache_nway.sv
// dcache_nway: NUM_WAYS-way set-associative write-back, write-allocate data cache with round-robin replacement.
// Defining DCACHE_FLUSH_EN adds the flush_req/flush_done whole-cache flush port and FLUSH state.
module dcache_nway #(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned NUM_SETS   = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DCACHE_FLUSH_EN
    input  logic        flush_req,
    output logic        flush_done,
`endif
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    input  logic        cpu_wen,
    input  logic        cpu_ren,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    output logic [3:0]  iomem_wmask,
    output logic        iomem_wen,
    output logic        iomem_ren,
    input  logic [31:0] iomem_rdata,
    input  logic        iomem_ready
);
    localparam int unsigned OFF   = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 30 - OFF - IDX_W;
    localparam int unsigned OFF_W = (OFF > 0) ? OFF : 1;
    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITEBACK, S_REFILL, S_RESPOND
`ifdef DCACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   way_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OFF_W-1:0]   word_q;
    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0] dirty_q [NUM_WAYS];
    logic [WAY_W-1:0]   rr_q     [NUM_SETS];
    logic [TAG_W-1:0]   tag_mem  [NUM_WAYS][NUM_SETS];
    logic [31:0]        data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];
`ifdef DCACHE_FLUSH_EN
    logic               wb_flush_q;
`endif

    logic [OFF_W-1:0]   cpu_word, word_next;
    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic               hit, free, victim_dirty, req, take_req, take_flush;
    logic               last_word, last_line, flush_line_dirty;
    logic [WAY_W-1:0]   hit_way, free_way, victim_way, rr_next;

    assign cpu_word  = OFF_W'(cpu_addr[31:2] & 30'(LINE_WORDS - 1));
    assign cpu_idx   = IDX_W'(cpu_addr >> (OFF + 2));
    assign cpu_tag   = TAG_W'(cpu_addr >> (OFF + IDX_W + 2));
    assign last_word = (word_q == OFF_W'(LINE_WORDS - 1));
    assign word_next = last_word ? '0 : word_q + OFF_W'(1);
    assign last_line = (idx_q == IDX_W'(NUM_SETS - 1)) && (way_q == WAY_W'(NUM_WAYS - 1));
    assign flush_line_dirty = valid_q[way_q][idx_q] && dirty_q[way_q][idx_q];

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                              input logic [OFF_W-1:0] w);
        line_addr = (32'(t) << (IDX_W + OFF + 2)) | (32'(i) << (OFF + 2)) | (32'(w) << 2);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
        merge = old;
        for (int unsigned b = 0; b < 4; b++)
            if (m[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    // Lookup, victim choice and next-state decode
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        free = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[WAY_W'(w)][cpu_idx] && tag_mem[WAY_W'(w)][cpu_idx] == cpu_tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!free && !valid_q[WAY_W'(w)][cpu_idx]) begin
                free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        victim_way   = free ? free_way : rr_q[cpu_idx];
        victim_dirty = !free && dirty_q[victim_way][cpu_idx];
        rr_next      = (NUM_WAYS == 1) ? '0 : rr_q[cpu_idx] + WAY_W'(1);
        req          = (cpu_ren || cpu_wen) && !cpu_ready;
        take_flush   = 1'b0;
`ifdef DCACHE_FLUSH_EN
        req        = req && !flush_done;
        take_flush = (state_q == S_IDLE) && flush_req && !cpu_ready && !flush_done;
`endif
        take_req = (state_q == S_IDLE) && req && !take_flush;
        state_d  = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_req && !hit) state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
`ifdef DCACHE_FLUSH_EN
                if (take_flush) state_d = S_FLUSH;
`endif
            end
            S_WRITEBACK: begin
                if (iomem_ready && last_word) begin
`ifdef DCACHE_FLUSH_EN
                    state_d = wb_flush_q ? S_FLUSH : S_REFILL;
`else
                    state_d = S_REFILL;
`endif
                end
            end
            S_REFILL:  if (iomem_ready && last_word) state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
`ifdef DCACHE_FLUSH_EN
            S_FLUSH: begin
                if (flush_line_dirty) state_d = S_WRITEBACK;
                else if (last_line)   state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, line metadata and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wmask <= '0;
            iomem_wen   <= 1'b0;
            iomem_ren   <= 1'b0;
            way_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            valid_q     <= '{default: '0};
            dirty_q     <= '{default: '0};
            rr_q        <= '{default: '0};
`ifdef DCACHE_FLUSH_EN
            flush_done  <= 1'b0;
            wb_flush_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cpu_ready <= 1'b0;
`ifdef DCACHE_FLUSH_EN
            flush_done <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (take_req && hit) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= cpu_wen ? '0 : data_mem[hit_way][cpu_idx][cpu_word];
                        if (cpu_wen && cpu_wmask != '0) dirty_q[hit_way][cpu_idx] <= 1'b1;
                    end else if (take_req) begin
                        way_q  <= victim_way;
                        idx_q  <= cpu_idx;
                        word_q <= '0;
                        if (!free) rr_q[cpu_idx] <= rr_next;
                        if (victim_dirty) begin
                            iomem_wen   <= 1'b1;
                            iomem_wmask <= 4'hF;
                            iomem_addr  <= line_addr(tag_mem[victim_way][cpu_idx], cpu_idx, '0);
                            iomem_wdata <= data_mem[victim_way][cpu_idx][OFF_W'(0)];
                        end else begin
                            iomem_ren  <= 1'b1;
                            iomem_addr <= line_addr(cpu_tag, cpu_idx, '0);
                        end
                    end
`ifdef DCACHE_FLUSH_EN
                    if (take_flush) begin
                        way_q <= '0;
                        idx_q <= '0;
                    end
`endif
                end
                S_WRITEBACK: begin
                    if (iomem_ready) begin
                        word_q <= word_next;
                        if (last_word) begin
                            iomem_wen   <= 1'b0;
                            iomem_wmask <= '0;
                            iomem_wdata <= '0;
`ifdef DCACHE_FLUSH_EN
                            if (wb_flush_q) begin
                                wb_flush_q <= 1'b0;
                                dirty_q[way_q][idx_q] <= 1'b0;
                            end else begin
                                iomem_ren  <= 1'b1;
                                iomem_addr <= line_addr(cpu_tag, idx_q, '0);
                            end
`else
                            iomem_ren  <= 1'b1;
                            iomem_addr <= line_addr(cpu_tag, idx_q, '0);
`endif
                        end else begin
                            iomem_addr  <= line_addr(tag_mem[way_q][idx_q], idx_q, word_next);
                            iomem_wdata <= data_mem[way_q][idx_q][word_next];
                        end
                    end
                end
                S_REFILL: begin
                    if (iomem_ready) begin
                        word_q <= word_next;
                        if (last_word) begin
                            iomem_ren <= 1'b0;
                            valid_q[way_q][idx_q] <= 1'b1;
                            dirty_q[way_q][idx_q] <= 1'b0;
                        end else begin
                            iomem_addr <= line_addr(cpu_tag, idx_q, word_next);
                        end
                    end
                end
                S_RESPOND: begin
                    cpu_ready <= 1'b1;
                    if (cpu_wen) begin
                        cpu_rdata <= '0;
                        if (cpu_wmask != '0) dirty_q[way_q][idx_q] <= 1'b1;
                    end else begin
                        cpu_rdata <= data_mem[way_q][idx_q][cpu_word];
                    end
                end
`ifdef DCACHE_FLUSH_EN
                S_FLUSH: begin
                    if (flush_line_dirty) begin
                        word_q      <= '0;
                        wb_flush_q  <= 1'b1;
                        iomem_wen   <= 1'b1;
                        iomem_wmask <= 4'hF;
                        iomem_addr  <= line_addr(tag_mem[way_q][idx_q], idx_q, '0);
                        iomem_wdata <= data_mem[way_q][idx_q][OFF_W'(0)];
                    end else begin
                        valid_q[way_q][idx_q] <= 1'b0;
                        if (last_line) begin
                            flush_done <= 1'b1;
                        end else if (way_q == WAY_W'(NUM_WAYS - 1)) begin
                            way_q <= '0;
                            idx_q <= idx_q + IDX_W'(1);
                        end else begin
                            way_q <= way_q + WAY_W'(1);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity lives in valid_q
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (take_req && hit && cpu_wen)
                data_mem[hit_way][cpu_idx][cpu_word] <= merge(data_mem[hit_way][cpu_idx][cpu_word], cpu_wdata, cpu_wmask);
            if (state_q == S_REFILL && iomem_ready) begin
                data_mem[way_q][idx_q][word_q] <= iomem_rdata;
                if (last_word) tag_mem[way_q][idx_q] <= cpu_tag;
            end
            if (state_q == S_RESPOND && cpu_wen)
                data_mem[way_q][idx_q][cpu_word] <= merge(data_mem[way_q][idx_q][cpu_word], cpu_wdata, cpu_wmask);
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway: table-driven CPU operations with an iomem transfer scoreboard, plus reset and flush sequences.
// Memory model returns data equal to the word address with a small random latency.
module tb_dcache_nway;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_wen, cpu_ren, cpu_ready;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic [3:0]  iomem_wmask;
    logic        iomem_wen, iomem_ren, iomem_ready;
`ifdef DCACHE_FLUSH_EN
    logic        flush_req, flush_done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        logic        hit;
        logic        wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_w0;
    } vec_t;
    vec_t vecs[17];

    dcache_nway dut (
        .clk(clk),
        .reset(reset),
`ifdef DCACHE_FLUSH_EN
        .flush_req(flush_req),
        .flush_done(flush_done),
`endif
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask),
        .cpu_wen(cpu_wen),
        .cpu_ren(cpu_ren),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_wmask(iomem_wmask),
        .iomem_wen(iomem_wen),
        .iomem_ren(iomem_ren),
        .iomem_rdata(iomem_rdata),
        .iomem_ready(iomem_ready)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Memory slave: one-cycle ready pulse per word after 0..2 wait cycles
    int mem_delay = 0;
    always @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else if (!iomem_ready && (iomem_ren || iomem_wen)) begin
            if (mem_delay == 0) begin
                iomem_ready <= 1'b1;
                iomem_rdata <= iomem_addr;
                mem_delay   <= int'($urandom_range(0, 2));
            end else begin
                mem_delay <= mem_delay - 1;
            end
        end else begin
            iomem_ready <= 1'b0;
        end
    end

    // Scoreboard: every transfer about to complete is matched against the expected queue
    always @(negedge clk) begin
        if (!reset && iomem_ready && (iomem_ren || iomem_wen)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_iomem: got wen=%b addr %h, want no transfer", iomem_wen, iomem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check32("iomem_wen", {31'b0, iomem_wen}, {31'b0, mon_e.we});
                check32("iomem_addr", iomem_addr, mon_e.addr);
                check32("iomem_wmask", {28'b0, iomem_wmask}, mon_e.we ? 32'hF : 32'h0);
                if (mon_e.we) check32("iomem_wdata", iomem_wdata, mon_e.data);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                                input logic [31:0] rd, input logic hit, input logic wb,
                                input logic [31:0] wba, input logic [31:0] wbw0);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.mask = m; v.rdata = rd;
        v.hit = hit; v.wb = wb; v.wb_addr = wba; v.wb_w0 = wbw0;
        return v;
    endfunction

    task automatic push_line(input logic we, input logic [31:0] base, input logic [31:0] w0);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.we   = we;
            e.addr = base + 32'(4 * k);
            e.data = (k == 0) ? w0 : base + 32'(4 * k);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int  n;
        logic got;
        if (v.wb)   push_line(1'b1, v.wb_addr, v.wb_w0);
        if (!v.hit) push_line(1'b0, v.addr & ~32'hF, v.addr & ~32'hF);
        @(negedge clk);
        cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_wmask = v.mask;
        cpu_wen = v.we; cpu_ren = !v.we;
        n = 0;
        got = 1'b0;
        while (!got && n < 500) begin
            @(posedge clk);
            #1;
            n++;
            got = cpu_ready;
        end
        check32({tag, "_ready"}, {31'b0, got}, 32'd1);
        if (got) begin
            check32({tag, "_rdata"}, cpu_rdata, v.rdata);
            if (v.hit) check32({tag, "_hit_latency"}, 32'(n), 32'd1);
        end
        @(negedge clk);
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
        check32({tag, "_pending_iomem"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_wen = 1'b0;
        cpu_ren = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0; cpu_wen = 1'b0; cpu_ren = 1'b0;
`ifdef DCACHE_FLUSH_EN
        flush_req = 1'b0;
`endif
        vecs[0]  = mk(0, 32'h100,  0, 4'h0, 32'h100,      0, 0, 0, 0);
        vecs[1]  = mk(0, 32'h108,  0, 4'h0, 32'h108,      1, 0, 0, 0);
        vecs[2]  = mk(1, 32'h104,  32'hAABBCCDD, 4'b0010, 0, 1, 0, 0, 0);
        vecs[3]  = mk(0, 32'h104,  0, 4'h0, 32'h0000CC04, 1, 0, 0, 0);
        vecs[4]  = mk(0, 32'h000,  0, 4'h0, 32'h000,      0, 0, 0, 0);
        vecs[5]  = mk(0, 32'h200,  0, 4'h0, 32'h200,      0, 0, 0, 0);
        vecs[6]  = mk(0, 32'h400,  0, 4'h0, 32'h400,      0, 0, 0, 0);
        vecs[7]  = mk(0, 32'h600,  0, 4'h0, 32'h600,      0, 0, 0, 0);
        vecs[8]  = mk(1, 32'h000,  32'h11111111, 4'hF, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 32'h800,  0, 4'h0, 32'h800,      0, 1, 32'h000, 32'h11111111);
        vecs[10] = mk(0, 32'h000,  0, 4'h0, 32'h000,      0, 0, 0, 0);
        vecs[11] = mk(0, 32'h600,  0, 4'h0, 32'h600,      1, 0, 0, 0);
        vecs[12] = mk(0, 32'h200,  0, 4'h0, 32'h200,      0, 0, 0, 0);
        vecs[13] = mk(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 32'h1000, 0, 4'h0, 32'hDEADBEEF, 1, 0, 0, 0);
        vecs[15] = mk(0, 32'h800,  0, 4'h0, 32'h800,      1, 0, 0, 0);
        vecs[16] = mk(0, 32'h108,  0, 4'h0, 32'h108,      1, 0, 0, 0);

        do_reset();
        check32("rst_cpu_ready",   {31'b0, cpu_ready}, 32'd0);
        check32("rst_cpu_rdata",   cpu_rdata, 32'd0);
        check32("rst_iomem_ren",   {31'b0, iomem_ren}, 32'd0);
        check32("rst_iomem_wen",   {31'b0, iomem_wen}, 32'd0);
        check32("rst_iomem_wmask", {28'b0, iomem_wmask}, 32'd0);
        check32("rst_iomem_addr",  iomem_addr, 32'd0);
        check32("rst_iomem_wdata", iomem_wdata, 32'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("op%0d", i));

        // cpu_rdata holds after the ready pulse
        repeat (3) @(posedge clk);
        #1;
        check32("rdata_hold", cpu_rdata, 32'h108);
        check32("ready_idle", {31'b0, cpu_ready}, 32'd0);

        // Reset during the second refill read
        push_line(1'b0, 32'h2000, 32'h2000);
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        @(negedge clk);
        cpu_addr = 32'h2000; cpu_ren = 1'b1;
        n = 0;
        while (n < 200 && !(iomem_ren && iomem_addr == 32'h2004)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check32("rst_mid_second_read_seen", {31'b0, iomem_ren && iomem_addr == 32'h2004}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("rst_mid_iomem_ren", {31'b0, iomem_ren}, 32'd0);
        check32("rst_mid_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        cpu_ren = 1'b0;
        reset = 1'b0;
        check32("rst_mid_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_op(mk(0, 32'h2000, 0, 4'h0, 32'h2000, 0, 0, 0, 0), "post_rst_2000");
        run_op(mk(0, 32'h100,  0, 4'h0, 32'h100,  0, 0, 0, 0), "post_rst_100");

`ifdef DCACHE_FLUSH_EN
        do_reset();
        run_op(mk(1, 32'h000,  32'h11111111, 4'hF, 0, 0, 0, 0, 0), "fl_st0");
        run_op(mk(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0), "fl_st1000");
        run_op(mk(0, 32'h100,  0, 4'h0, 32'h100, 0, 0, 0, 0), "fl_ld100");
        push_line(1'b1, 32'h000,  32'h11111111);
        push_line(1'b1, 32'h1000, 32'hDEADBEEF);
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        n = 0;
        while (n < 2000 && !flush_done) begin
            @(posedge clk);
            #1;
            n++;
        end
        check32("flush_done_seen", {31'b0, flush_done}, 32'd1);
        @(posedge clk);
        #1;
        check32("flush_done_pulse", {31'b0, flush_done}, 32'd0);
        check32("flush_pending_writes", 32'(exp_q.size()), 32'd0);
        run_op(mk(0, 32'h100, 0, 4'h0, 32'h100, 0, 0, 0, 0), "post_flush_100");
`endif

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "timeout");
    end

endmodule
